// File: rtl/conv_pkg.sv
// Shared convolver constants and the flat window index rule used by the window
// generator, the datapath and its weight loader.
package conv_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FRAC_BIT    = 8;
  localparam int KERNEL_SIZE = 5;

  // Element (r, c) of a K x K window lives at flat index r*K + c.
  function automatic int win_index(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage, single port, read-before-write at the same address.
// Contents are deliberately not reset; the window generator never flags stale data.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int DEPTH      = 28,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_data;
    end
  end

  // Asynchronous read returns the value from the previous row before this write lands.
  assign o_data = r_mem[i_addr];

endmodule

// File: rtl/conv_window_generator.sv
// Raster-order pixel stream in, every complete K x K window out, using K-1 chained
// line buffers and a shifting K x K register array.
module conv_window_generator
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [DATA_WIDTH-1:0]                         pixel_in,
  input  logic                                          pixel_valid,
  output logic                                          pixel_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_window,
  output logic                                          window_valid,
  input  logic                                          window_ready,
  output logic                                          frame_done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_N  = KERNEL_SIZE - 1;

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  r_window_valid;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_win [KERNEL_SIZE][KERNEL_SIZE];

  logic                  w_accept;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_win_pos;
  logic [DATA_WIDTH-1:0] w_lb_out  [LB_N];
  logic [DATA_WIDTH-1:0] w_new_col [KERNEL_SIZE];

  assign pixel_ready  = ~r_window_valid | window_ready;
  assign w_accept     = pixel_valid & pixel_ready;
  assign w_col_last   = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_row_last   = (r_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_win_pos    = (r_row >= ROW_W'(KERNEL_SIZE - 1)) &&
                        (r_col >= COL_W'(KERNEL_SIZE - 1));
  assign window_valid = r_window_valid;
  assign frame_done   = r_frame_done;

  // Buffer 0 holds the previous row; each later buffer holds the row before that.
  for (genvar j = 0; j < LB_N; j++) begin : g_lb
    logic [DATA_WIDTH-1:0] w_lb_in;
    if (j == 0) begin : g_head
      assign w_lb_in = pixel_in;
    end else begin : g_tail
      assign w_lb_in = w_lb_out[j-1];
    end
    conv_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH),
      .ADDR_W    (COL_W)
    ) u_lb (
      .clk    (clk),
      .i_wr_en(w_accept),
      .i_addr (r_col),
      .i_data (w_lb_in),
      .o_data (w_lb_out[j])
    );
  end

  always_comb begin
    for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
      w_new_col[r] = w_lb_out[KERNEL_SIZE-2-r];
    end
    w_new_col[KERNEL_SIZE-1] = pixel_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][KERNEL_SIZE-1] <= w_new_col[r];
      end
    end
  end

  // A pending window blocks accepts, so it can only be replaced or retired together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col          <= '0;
      r_row          <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
      if (w_accept) begin
        r_window_valid <= w_win_pos;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (window_ready) begin
        r_window_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    pixel_window = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        pixel_window[win_index(r, c, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_generator.sv
// Self-checking bench: an image-array reference model predicts every window,
// the window_valid/pixel_ready behaviour and frame_done for each cycle.
module tb_conv_window_generator;

  localparam int DW    = 16;
  localparam int K     = 5;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX   = IMG_W * IMG_H;
  localparam int WINW  = K * K * DW;
  localparam int WINS  = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int RAMP  = 0;
  localparam int CNST  = 1;
  localparam int RND   = 2;
  localparam int BUDGET = 20000;

  logic            clk;
  logic            reset;
  logic [DW-1:0]   pixel_in;
  logic            pixel_valid;
  logic            pixel_ready;
  logic [WINW-1:0] pixel_window;
  logic            window_valid;
  logic            window_ready;
  logic            frame_done;

  conv_window_generator #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (IMG_W),
    .IMG_HEIGHT (IMG_H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_window(pixel_window),
    .window_valid(window_valid),
    .window_ready(window_ready),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the current frame as a 2-D image plus pending windows.
  logic [DW-1:0]   img [IMG_H][IMG_W];
  logic [WINW-1:0] expQ [$];
  int              mr, mc;
  bit              doneNext;
  int              acceptCount;
  int              windowsSeen;
  int              doneSeen;
  int              checkCount;
  int              passCount;

  typedef struct {
    string name;
    int    frames;
    int    validPct;
    int    readyPct;
    int    mode;
    int    expWindows;
    int    expDone;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [WINW-1:0] act,
                             input logic [WINW-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelAccept(input logic [DW-1:0] pix);
    logic [WINW-1:0] w;
    img[mr][mc] = pix;
    if (mr >= K - 1 && mc >= K - 1) begin
      w = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          w[(r*K+c)*DW +: DW] = img[mr-K+1+r][mc-K+1+c];
      expQ.push_back(w);
    end
    acceptCount++;
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr++;
      if (mr == IMG_H) begin
        mr = 0;
        doneNext = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check settled outputs against the model.
  task automatic applyStimulus(input bit pv, input bit wr, input int mode);
    logic [DW-1:0] pix;
    bit expValid;
    bit expDone;
    @(negedge clk);
    case (mode)
      RAMP:    pix = DW'(mr * IMG_W + mc);
      CNST:    pix = 16'h0200;
      default: pix = DW'($urandom);
    endcase
    pixel_in     = pix;
    pixel_valid  = pv;
    window_ready = wr;
    #1;
    expValid = (expQ.size() != 0);
    expDone  = doneNext;
    doneNext = 1'b0;
    checkOutput("window_valid", WINW'(window_valid), WINW'(expValid));
    checkOutput("pixel_ready", WINW'(pixel_ready), WINW'(!expValid || wr));
    checkOutput("frame_done", WINW'(frame_done), WINW'(expDone));
    if (frame_done) doneSeen++;
    if (expValid) checkOutput("window_data", pixel_window, expQ[0]);
    if (expValid && wr) begin
      void'(expQ.pop_front());
      windowsSeen++;
    end
    if (pv && (!expValid || wr)) modelAccept(pix);
  endtask

  task automatic applyReset();
    reset        = 1'b0;
    pixel_valid  = 1'b0;
    window_ready = 1'b0;
    pixel_in     = '0;
    #1;
    checkOutput("rst_window_valid", WINW'(window_valid), '0);
    checkOutput("rst_frame_done", WINW'(frame_done), '0);
    checkOutput("rst_pixel_window", pixel_window, '0);
    expQ.delete();
    mr = 0; mc = 0; doneNext = 1'b0;
    acceptCount = 0; windowsSeen = 0; doneSeen = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_pixel_ready", WINW'(pixel_ready), WINW'(1));
  endtask

  task automatic runPixels(input int nPix, input int vPct, input int rPct,
                           input int mode, input bit drain);
    int target;
    int cycles;
    bit pv, wr;
    target = acceptCount + nPix;
    cycles = 0;
    while ((acceptCount < target || (drain && expQ.size() != 0)) && cycles < BUDGET) begin
      pv = (acceptCount < target) && ($urandom_range(99) < vPct);
      wr = (acceptCount >= target) || ($urandom_range(99) < rPct);
      applyStimulus(pv, wr, mode);
      cycles++;
    end
    checkOutput("cycle_budget", WINW'(cycles >= BUDGET), '0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    vecs[0] = '{"ramp",         1, 100, 100, RAMP, WINS,     1};
    vecs[1] = '{"const0200",    1, 100, 100, CNST, WINS,     1};
    vecs[2] = '{"validGaps",    1,  50, 100, RAMP, WINS,     1};
    vecs[3] = '{"backpressure", 1,  70,  60, RND,  WINS,     1};
    vecs[4] = '{"twoFrames",    2, 100, 100, RAMP, 2 * WINS, 2};
    #3;

    $display("[TB] first-window latency and contents");
    applyReset();
    for (int i = 0; i < 116; i++) applyStimulus(1'b1, 1'b1, RAMP);
    applyStimulus(1'b1, 1'b1, RAMP);
    checkOutput("no_early_window", WINW'(window_valid), '0);
    applyStimulus(1'b0, 1'b0, RAMP);
    checkOutput("first_valid", WINW'(window_valid), WINW'(1));
    checkOutput("elem0", WINW'(pixel_window[0 +: DW]), WINW'(0));
    checkOutput("elem12", WINW'(pixel_window[12*DW +: DW]), WINW'(58));
    checkOutput("elem24", WINW'(pixel_window[24*DW +: DW]), WINW'(116));
    runPixels(PIX - acceptCount, 100, 100, RAMP, 1'b1);
    checkOutput("first_frame_windows", WINW'(windowsSeen), WINW'(WINS));
    checkOutput("first_frame_done", WINW'(doneSeen), WINW'(1));

    $display("[TB] table-driven frames");
    for (int v = 0; v < 5; v++) begin
      applyReset();
      runPixels(vecs[v].frames * PIX, vecs[v].validPct, vecs[v].readyPct, vecs[v].mode, 1'b1);
      checkOutput({vecs[v].name, "_windows"}, WINW'(windowsSeen), WINW'(vecs[v].expWindows));
      checkOutput({vecs[v].name, "_frame_done"}, WINW'(doneSeen), WINW'(vecs[v].expDone));
    end

    $display("[TB] downstream hold");
    applyReset();
    for (int i = 0; i < 200 && expQ.size() == 0; i++) applyStimulus(1'b1, 1'b1, RAMP);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, RAMP);
    checkOutput("hold_window_valid", WINW'(window_valid), WINW'(1));
    checkOutput("hold_pixel_ready", WINW'(pixel_ready), '0);
    runPixels(PIX - acceptCount, 100, 100, RAMP, 1'b1);
    checkOutput("hold_windows", WINW'(windowsSeen), WINW'(WINS));

    $display("[TB] mid-frame reset");
    applyReset();
    runPixels(300, 100, 100, RAMP, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_valid", WINW'(window_valid), WINW'(expQ.size() != 0));
    applyReset();
    runPixels(PIX, 100, 100, RND, 1'b1);
    checkOutput("post_reset_windows", WINW'(windowsSeen), WINW'(WINS));
    checkOutput("post_reset_done", WINW'(doneSeen), WINW'(1));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
